// File: rtl/mcd_mem_arb.sv
// rtl/mcd_mem_arb.sv - shared memory port arbiter for sub-CPU and CDC DMA
// CDC DMA words are posted into a 4-entry FIFO and drained whenever the sub-CPU is not using the port.

module mcd_mem_arb #(
    parameter int AW         = 19,
    parameter int STARVE_MAX = 8
) (
    input  logic          clk_asic,
    input  logic          rst,
    input  logic          i_sub_req,
    input  logic          i_sub_we,
    input  logic [AW-1:0] i_sub_addr,
    input  logic [15:0]   i_sub_di,
    output logic [15:0]   o_sub_do,
    output logic          o_sub_ack,
    input  logic          i_dma_push,
    input  logic [AW-1:0] i_dma_addr,
    input  logic [15:0]   i_dma_di,
    output logic          o_dma_full,
    output logic          o_dma_empty,
    output logic          o_mem_req,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [15:0]   o_mem_di,
    input  logic [15:0]   i_mem_do,
    input  logic          i_mem_ack
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SUB,
        ST_DMA
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t        r_state;
    state_t        w_state_nxt;

    logic [AW-1:0] r_fifo_addr [4];
    logic [15:0]   r_fifo_data [4];
    logic [1:0]    r_wr_ptr;
    logic [1:0]    r_rd_ptr;
    logic [2:0]    r_count;
    logic [3:0]    r_starve;

    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [15:0]   r_mem_di;
    logic          r_sub_ack;
    logic [15:0]   r_sub_do;
    logic          r_dma_full;
    logic          r_dma_empty;

    logic [1:0]    w_off [4];
    logic [3:0]    w_match;
    logic          w_hazard;
    logic          w_full;
    logic          w_nonempty;
    logic          w_starved;
    logic          w_sub_ok;
    logic          w_dma_ok;
    logic          w_grant_sub;
    logic          w_grant_dma;
    logic          w_pop;
    logic          w_push;
    logic [2:0]    w_count_nxt;

    // An entry is live when its distance from the read pointer is below the count.
    for (genvar g = 0; g < 4; g++) begin : g_slot
        assign w_off[g]   = 2'(g) - r_rd_ptr;
        assign w_match[g] = ({1'b0, w_off[g]} < r_count) && (r_fifo_addr[g] == i_sub_addr);
    end

    assign w_hazard   = i_sub_req && (w_match != 4'd0);
    assign w_full     = (r_count == 3'd4);
    assign w_nonempty = (r_count != 3'd0);
    assign w_starved  = (r_starve == STARVE_LIM);

    // The sub_req level seen during the sub_ack cycle still belongs to the finished access.
    assign w_sub_ok = i_sub_req && !r_sub_ack && !w_hazard && !w_full && (r_starve < STARVE_LIM);
    assign w_dma_ok = w_nonempty && (!i_sub_req || w_hazard || w_full || w_starved);

    assign w_pop       = (r_state == ST_DMA) && i_mem_ack;
    assign w_push      = i_dma_push && (!w_full || w_pop);
    assign w_count_nxt = r_count + {2'b00, w_push} - {2'b00, w_pop};

    always_ff @(posedge clk_asic) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_sub = 1'b0;
        w_grant_dma = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_dma_ok) begin
                    w_state_nxt = ST_DMA;
                    w_grant_dma = 1'b1;
                end else if (w_sub_ok) begin
                    w_state_nxt = ST_SUB;
                    w_grant_sub = 1'b1;
                end
            end
            ST_SUB: begin
                if (i_mem_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DMA: begin
                if (i_mem_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk_asic) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= i_dma_addr;
            r_fifo_data[r_wr_ptr] <= i_dma_di;
        end
    end

    always_ff @(posedge clk_asic) begin
        if (rst) begin
            r_wr_ptr    <= 2'd0;
            r_rd_ptr    <= 2'd0;
            r_count     <= 3'd0;
            r_starve    <= 4'd0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_di    <= 16'd0;
            r_sub_ack   <= 1'b0;
            r_sub_do    <= 16'd0;
            r_dma_full  <= 1'b0;
            r_dma_empty <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            r_count     <= w_count_nxt;
            r_dma_full  <= (w_count_nxt == 3'd4);
            r_dma_empty <= (w_count_nxt == 3'd0);

            if (!w_nonempty || w_grant_dma) begin
                r_starve <= 4'd0;
            end else if (w_grant_sub && !w_starved) begin
                r_starve <= r_starve + 4'd1;
            end

            if (w_grant_sub) begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= i_sub_we;
                r_mem_addr <= i_sub_addr;
                r_mem_di   <= i_sub_di;
            end else if (w_grant_dma) begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= 1'b1;
                r_mem_addr <= r_fifo_addr[r_rd_ptr];
                r_mem_di   <= r_fifo_data[r_rd_ptr];
            end else if (i_mem_ack && (r_state != ST_IDLE)) begin
                r_mem_req <= 1'b0;
            end

            r_sub_ack <= (r_state == ST_SUB) && i_mem_ack;
            if ((r_state == ST_SUB) && i_mem_ack) begin
                r_sub_do <= i_mem_do;
            end
        end
    end

    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_di    = r_mem_di;
    assign o_sub_ack   = r_sub_ack;
    assign o_sub_do    = r_sub_do;
    assign o_dma_full  = r_dma_full;
    assign o_dma_empty = r_dma_empty;

endmodule

// File: tb/tb_mcd_mem_arb.sv
// tb/tb_mcd_mem_arb.sv - self-checking bench for mcd_mem_arb with a queue-based reference model

module tb_mcd_mem_arb;

    localparam int AW = 19;
    localparam int SM = 8;

    logic          clk_asic = 1'b0;
    logic          rst      = 1'b1;
    logic          sub_req  = 1'b0;
    logic          sub_we   = 1'b0;
    logic [AW-1:0] sub_addr = '0;
    logic [15:0]   sub_di   = 16'd0;
    logic [15:0]   o_sub_do;
    logic          o_sub_ack;
    logic          dma_push = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic [15:0]   dma_di   = 16'd0;
    logic          o_dma_full;
    logic          o_dma_empty;
    logic          o_mem_req;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [15:0]   o_mem_di;
    logic [15:0]   mem_do   = 16'd0;
    logic          mem_ack  = 1'b0;

    always #5 clk_asic = ~clk_asic;

    mcd_mem_arb #(.AW(AW), .STARVE_MAX(SM)) dut (
        .clk_asic    (clk_asic),
        .rst         (rst),
        .i_sub_req   (sub_req),
        .i_sub_we    (sub_we),
        .i_sub_addr  (sub_addr),
        .i_sub_di    (sub_di),
        .o_sub_do    (o_sub_do),
        .o_sub_ack   (o_sub_ack),
        .i_dma_push  (dma_push),
        .i_dma_addr  (dma_addr),
        .i_dma_di    (dma_di),
        .o_dma_full  (o_dma_full),
        .o_dma_empty (o_dma_empty),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_di    (o_mem_di),
        .i_mem_do    (mem_do),
        .i_mem_ack   (mem_ack)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: FIFO as queues, memory as a sparse array.
    logic [AW-1:0] q_addr [$];
    logic [15:0]   q_data [$];
    logic [15:0]   shadow [int];
    logic [15:0]   ext_mem [int];
    int            m_busy = 0;
    logic          m_req = 0, m_we = 0, m_ack = 0;
    logic [AW-1:0] m_addr = '0;
    logic [15:0]   m_di = 0, m_do = 0;
    int            m_starve = 0;

    function automatic logic [15:0] dflt(input int a);
        return 16'(a) ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] rd_shadow(input logic [AW-1:0] a);
        return shadow.exists(int'(a)) ? shadow[int'(a)] : dflt(int'(a));
    endfunction

    function automatic logic [15:0] rd_ext(input logic [AW-1:0] a);
        return ext_mem.exists(int'(a)) ? ext_mem[int'(a)] : dflt(int'(a));
    endfunction

    task automatic model_step();
        int n;
        bit hz, pop, sack, want_dma, want_sub;
        n = q_addr.size();
        if (rst) begin
            q_addr.delete(); q_data.delete();
            m_busy = 0; m_req = 0; m_we = 0; m_addr = '0; m_di = 0;
            m_ack = 0; m_do = 0; m_starve = 0;
            return;
        end
        hz = 0;
        foreach (q_addr[k]) if (q_addr[k] == sub_addr) hz = 1;
        hz   = hz & sub_req;
        pop  = (m_busy == 2) && mem_ack;
        sack = (m_busy == 1) && mem_ack;
        if (m_busy != 0 && mem_ack) begin
            if (sack) m_do = m_we ? mem_do : rd_shadow(m_addr);
            if (m_we) shadow[int'(m_addr)] = m_di;
            m_busy = 0;
            m_req  = 0;
        end else if (m_busy == 0) begin
            want_dma = (n > 0) && (!sub_req || hz || n == 4 || m_starve == SM);
            want_sub = sub_req && !m_ack && !hz && n < 4 && m_starve < SM;
            if (want_dma) begin
                m_busy = 2; m_req = 1; m_we = 1;
                m_addr = q_addr[0]; m_di = q_data[0];
                m_starve = 0;
            end else if (want_sub) begin
                m_busy = 1; m_req = 1; m_we = sub_we;
                m_addr = sub_addr; m_di = sub_di;
                if (n > 0 && m_starve < SM) m_starve++;
            end
        end
        if (n == 0) m_starve = 0;
        if (pop) begin
            void'(q_addr.pop_front());
            void'(q_data.pop_front());
        end
        if (dma_push && (n < 4 || pop)) begin
            q_addr.push_back(dma_addr);
            q_data.push_back(dma_di);
        end
        m_ack = sack;
    endtask

    task automatic compare_step();
        check("mem_req", o_mem_req, m_req);
        if (m_req) begin
            check("mem_we", o_mem_we, m_we);
            check("mem_addr", o_mem_addr, m_addr);
            check("mem_di", o_mem_di, m_di);
        end
        check("sub_ack", o_sub_ack, m_ack);
        if (m_ack) check("sub_do", o_sub_do, m_do);
        check("dma_full", o_dma_full, q_addr.size() == 4);
        check("dma_empty", o_dma_empty, q_addr.size() == 0);
    endtask

    initial forever begin
        @(posedge clk_asic);
        model_step();
    end

    initial forever begin
        @(negedge clk_asic);
        if (chk_en) compare_step();
    end

    // Bench-side sub master and memory controller.
    bit            sub_cont = 0, rand_sub = 0, rand_lat = 0, mem_stall = 0, prev_req = 0;
    int            fixed_lat = 1, lat = 1, lat_cnt = 0, n_subacks = 0;
    bit            grants [$];
    logic [AW-1:0] wlog_a [$];
    logic [15:0]   wlog_d [$];

    task automatic sub_start(input logic [AW-1:0] a, input logic w, input logic [15:0] d);
        sub_req = 1; sub_addr = a; sub_we = w; sub_di = d;
    endtask

    task automatic sub_step();
        if (o_sub_ack) n_subacks++;
        if (sub_req) begin
            if (o_sub_ack && !sub_cont) sub_req = 0;
        end else if (rand_sub && $urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 1) == 1) sub_start(AW'($urandom_range(0, 7)), 1'($urandom), 16'($urandom));
            else sub_start(AW'(32'h2000 + $urandom_range(0, 3)), 1'($urandom), 16'($urandom));
        end
    endtask

    task automatic mem_step();
        if (o_mem_req && !prev_req) grants.push_back(o_mem_we);
        prev_req = o_mem_req;
        mem_ack  = 0;
        if (!o_mem_req) begin
            lat_cnt = 0;
            lat = rand_lat ? int'($urandom_range(1, 3)) : fixed_lat;
        end else if (!mem_stall) begin
            lat_cnt++;
            if (lat_cnt >= lat) begin
                mem_ack = 1;
                lat_cnt = 0;
                if (o_mem_we) begin
                    ext_mem[int'(o_mem_addr)] = o_mem_di;
                    wlog_a.push_back(o_mem_addr);
                    wlog_d.push_back(o_mem_di);
                    mem_do = 16'hDEAD;
                end else begin
                    mem_do = rd_ext(o_mem_addr);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk_asic);
        #1;
        dma_push = 0;
        sub_step();
        mem_step();
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [15:0] d);
        dma_addr = a; dma_di = d; dma_push = 1;
        tick();
    endtask

    function automatic int count_w();
        int c = 0;
        foreach (grants[k]) if (grants[k]) c++;
        return c;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, first_w, between, seen_w;
        tick();
        chk_en = 1;
        repeat (2) tick();
        rst = 0;

        // Idle after reset
        repeat (10) tick();
        check("idle_mem_req", o_mem_req, 0);
        check("idle_dma_empty", o_dma_empty, 1);
        check("idle_dma_full", o_dma_full, 0);
        check("idle_subacks", n_subacks, 0);
        check("rst_mem_addr", o_mem_addr, 0);
        check("rst_mem_we", o_mem_we, 0);
        check("rst_mem_di", o_mem_di, 0);
        check("rst_sub_do", o_sub_do, 0);

        // Four DMA writes, memory latency 2
        fixed_lat = 2;
        wlog_a.delete(); wlog_d.delete();
        for (int i = 0; i < 4; i++) push(AW'(32'h100 + i), 16'(32'hA000 + i));
        for (t = 0; t < 100 && !(wlog_a.size() == 4 && o_dma_empty && !o_mem_req); t++) tick();
        check("dma4_done", t < 100, 1);
        for (int i = 0; i < 4 && i < wlog_a.size(); i++) begin
            check("dma4_addr", wlog_a[i], 32'h100 + i);
            check("dma4_data", wlog_d[i], 32'hA000 + i);
        end
        check("dma4_empty", o_dma_empty, 1);

        // Starvation bound with a continuously held sub read
        fixed_lat = 1;
        grants.delete(); wlog_a.delete(); wlog_d.delete();
        sub_cont = 1;
        sub_start(AW'(32'h2000), 1'b0, 16'd0);
        push(AW'(32'h300), 16'h3300);
        push(AW'(32'h301), 16'h3301);
        for (t = 0; t < 400 && count_w() < 2; t++) tick();
        check("starve_done", t < 400, 1);
        sub_cont = 0;
        for (t = 0; t < 50 && sub_req; t++) tick();
        check("starve_sub_end", sub_req, 0);
        first_w = -1; between = 0; seen_w = 0;
        foreach (grants[k]) begin
            if (grants[k]) begin
                seen_w++;
                if (seen_w == 1) first_w = k;
            end else if (seen_w == 1) begin
                between++;
            end
        end
        check("starve_first_dma", first_w, 9);
        check("starve_between", between, 8);
        check("starve_wr0", wlog_a.size() > 0 ? wlog_a[0] : '1, 32'h300);
        check("starve_wr1", wlog_a.size() > 1 ? wlog_a[1] : '1, 32'h301);

        // Read-after-write hazard
        repeat (3) tick();
        grants.delete();
        push(AW'(32'h40), 16'h1234);
        sub_start(AW'(32'h40), 1'b0, 16'd0);
        for (t = 0; t < 50 && !o_sub_ack; t++) tick();
        check("raw_ack", o_sub_ack, 1);
        check("raw_sub_do", o_sub_do, 16'h1234);
        check("raw_order", grants.size() >= 2 && grants[0] == 1 && grants[1] == 0, 1);

        // Overflow with the memory stalled
        repeat (3) tick();
        mem_stall = 1;
        wlog_a.delete(); wlog_d.delete();
        for (int i = 0; i < 5; i++) push(AW'(32'h500 + i), 16'(32'hB000 + i));
        check("ovf_full", o_dma_full, 1);
        mem_stall = 0;
        for (t = 0; t < 20 && wlog_a.size() < 1; t++) tick();
        tick();
        check("ovf_not_full", o_dma_full, 0);
        for (t = 0; t < 100 && !(o_dma_empty && !o_mem_req); t++) tick();
        repeat (10) tick();
        check("ovf_writes", wlog_a.size(), 4);
        for (int i = 0; i < 4 && i < wlog_a.size(); i++) check("ovf_addr", wlog_a[i], 32'h500 + i);

        // Reset during a DMA transaction
        mem_stall = 1;
        wlog_a.delete(); wlog_d.delete();
        for (int i = 0; i < 3; i++) push(AW'(32'h600 + i), 16'(32'hC000 + i));
        tick();
        check("rst_pre_req", o_mem_req, 1);
        rst = 1;
        tick();
        check("rst_mem_req", o_mem_req, 0);
        check("rst_dma_empty", o_dma_empty, 1);
        rst = 0;
        mem_stall = 0;
        repeat (20) tick();
        check("rst_no_writes", wlog_a.size(), 0);

        // Randomized traffic
        rand_sub = 1; rand_lat = 1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                dma_addr = AW'($urandom_range(0, 7));
                dma_di   = 16'($urandom);
                dma_push = 1;
            end
            tick();
        end
        rand_sub = 0;
        for (t = 0; t < 500 && !(!sub_req && o_dma_empty && !o_mem_req); t++) tick();
        check("rand_drain", t < 500, 1);
        for (int a = 0; a < 8; a++) check("rand_mem", rd_ext(AW'(a)), rd_shadow(AW'(a)));

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
